// File: rtl/led_bank_pkg.sv
// Shared types and helpers for the LED driver bank: channel modes, burst
// sequencer states and the counter-width helper.
package led_bank_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    B_ON    = 2'd0,
    B_OFF   = 2'd1,
    B_PAUSE = 2'd2
  } burst_state_t;

  // Width for a counter that must reach (largest of a, b, c) - 1; never below 1 bit.
  function automatic int clog2_max(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running clock divider producing a single-cycle tick every DIV enabled
// cycles; the count freezes while enable_i is low.
module tick_prescaler #(
  parameter int DIV = 50_000
) (
  input  logic fpga_CLK,
  input  logic fpga_NRST,
  input  logic enable_i,
  output logic tick_o
);

  if (DIV < 2) begin : g_div_chk
    $error("tick_prescaler: DIV must be at least 2");
  end

  localparam int DW = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [DW-1:0] DIV_TERM = DW'(DIV - 1);

  logic [DW-1:0] div_cnt;

  // Combinational so the tick lines up with the wrap edge of div_cnt.
  assign tick_o = enable_i && (div_cnt == DIV_TERM);

  always_ff @(posedge fpga_CLK or negedge fpga_NRST) begin
    if (!fpga_NRST) begin
      div_cnt <= '0;
    end else if (enable_i) begin
      div_cnt <= tick_o ? '0 : div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_blink_bank.sv
// Bank of N_CH LED drivers (OFF / ON / BLINK / BURST) stepped by one shared
// prescaler tick; each channel restarts its pattern whenever its mode changes.
module led_blink_bank
  import led_bank_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int TICK_FREQ   = 1000,
  parameter int N_CH        = 4,
  parameter int HALF_PERIOD = 500,
  parameter int PULSE_LEN   = 100,
  parameter int PAUSE_LEN   = 1000,
  parameter int BURST_LEN   = 3
) (
  input  logic              fpga_CLK,
  input  logic              fpga_NRST,
  input  logic              enable_i,
  input  logic [2*N_CH-1:0] mode_i,
  output logic              tick_o,
  output logic [N_CH-1:0]   led_o
);

  localparam int DIV  = CLK_FREQ / TICK_FREQ;
  localparam int PH_W = clog2_max(HALF_PERIOD, PULSE_LEN, PAUSE_LEN);
  localparam int PC_W = $clog2(BURST_LEN + 1);

  localparam logic [PH_W-1:0] HP_TERM    = PH_W'(HALF_PERIOD - 1);
  localparam logic [PH_W-1:0] PULSE_TERM = PH_W'(PULSE_LEN - 1);
  localparam logic [PH_W-1:0] PAUSE_TERM = PH_W'(PAUSE_LEN - 1);
  localparam logic [PC_W-1:0] BURST_TERM = PC_W'(BURST_LEN);

  if (DIV < 2 || HALF_PERIOD < 1 || PULSE_LEN < 1 || PAUSE_LEN < 1 || BURST_LEN < 1) begin : g_param_chk
    $error("led_blink_bank: DIV must be >= 2 and every length parameter >= 1");
  end

  logic tick;

  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .fpga_CLK  (fpga_CLK),
    .fpga_NRST (fpga_NRST),
    .enable_i  (enable_i),
    .tick_o    (tick)
  );

  assign tick_o = tick;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    mode_t             mode_q;
    mode_t             mode_nx;
    burst_state_t      bstate;
    logic [PH_W-1:0]   phase_cnt;
    logic [PC_W-1:0]   pulse_cnt;
    logic              led_q;

    assign mode_nx  = mode_t'(mode_i[2*c +: 2]);
    assign led_o[c] = led_q;

    always_ff @(posedge fpga_CLK or negedge fpga_NRST) begin
      if (!fpga_NRST) begin
        mode_q    <= MODE_OFF;
        bstate    <= B_ON;
        phase_cnt <= '0;
        pulse_cnt <= '0;
        led_q     <= 1'b0;
      end else if (mode_nx != mode_q) begin
        // Entry wins over a coincident tick so every pattern starts from a clean phase.
        mode_q    <= mode_nx;
        bstate    <= B_ON;
        phase_cnt <= '0;
        pulse_cnt <= '0;
        led_q     <= (mode_nx != MODE_OFF);
      end else if (tick) begin
        case (mode_q)
          MODE_OFF: led_q <= 1'b0;
          MODE_ON:  led_q <= 1'b1;
          MODE_BLINK: begin
            if (phase_cnt == HP_TERM) begin
              phase_cnt <= '0;
              led_q     <= ~led_q;
            end else begin
              phase_cnt <= phase_cnt + 1'b1;
            end
          end
          MODE_BURST: begin
            case (bstate)
              B_ON: begin
                if (phase_cnt == PULSE_TERM) begin
                  phase_cnt <= '0;
                  pulse_cnt <= pulse_cnt + 1'b1;
                  bstate    <= B_OFF;
                  led_q     <= 1'b0;
                end else begin
                  phase_cnt <= phase_cnt + 1'b1;
                end
              end
              B_OFF: begin
                if (phase_cnt == PULSE_TERM) begin
                  phase_cnt <= '0;
                  if (pulse_cnt == BURST_TERM) begin
                    pulse_cnt <= '0;
                    bstate    <= B_PAUSE;
                  end else begin
                    bstate    <= B_ON;
                    led_q     <= 1'b1;
                  end
                end else begin
                  phase_cnt <= phase_cnt + 1'b1;
                end
              end
              B_PAUSE: begin
                if (phase_cnt == PAUSE_TERM) begin
                  phase_cnt <= '0;
                  bstate    <= B_ON;
                  led_q     <= 1'b1;
                end else begin
                  phase_cnt <= phase_cnt + 1'b1;
                end
              end
              default: begin
                phase_cnt <= '0;
                pulse_cnt <= '0;
                bstate    <= B_ON;
                led_q     <= 1'b1;
              end
            endcase
          end
          default: led_q <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_blink_bank.sv
// Bench for led_blink_bank: tick-count / ticks-since-entry reference model
// checked every cycle, plus hand-computed pattern and timing expectations.
module tb_led_blink_bank;

  localparam int N_CH = 4;
  localparam int DIV  = 10;
  localparam int HP   = 3;
  localparam int PL   = 1;
  localparam int PS   = 4;
  localparam int BL   = 2;
  localparam int BP   = 2 * PL * BL + PS;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic [2*N_CH-1:0] mode = '0;
  logic              tick;
  logic [N_CH-1:0]   led;

  int errors = 0;
  int checks = 0;
  bit run_chk = 1'b0;

  always #5 clk = ~clk;

  led_blink_bank #(
    .CLK_FREQ    (10),
    .TICK_FREQ   (1),
    .N_CH        (N_CH),
    .HALF_PERIOD (HP),
    .PULSE_LEN   (PL),
    .PAUSE_LEN   (PS),
    .BURST_LEN   (BL)
  ) dut (
    .fpga_CLK  (clk),
    .fpga_NRST (rst_n),
    .enable_i  (en),
    .mode_i    (mode),
    .tick_o    (tick),
    .led_o     (led)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: enabled cycles since reset, plus per-channel mode and ticks since entry.
  int en_cnt;
  int m_mode [N_CH];
  int t_cnt  [N_CH];

  function automatic int model_led(input int md, input int t);
    int p;
    case (md)
      0: return 0;
      1: return 1;
      2: return ((t / HP) % 2 == 0) ? 1 : 0;
      default: begin
        p = t % BP;
        if (p < 2 * PL * BL) return ((p / PL) % 2 == 0) ? 1 : 0;
        return 0;
      end
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_cnt <= 0;
      for (int c = 0; c < N_CH; c++) begin
        m_mode[c] <= 0;
        t_cnt[c]  <= 0;
      end
    end else begin
      if (en) en_cnt <= en_cnt + 1;
      for (int c = 0; c < N_CH; c++) begin
        if (int'(mode[2*c +: 2]) != m_mode[c]) begin
          m_mode[c] <= int'(mode[2*c +: 2]);
          t_cnt[c]  <= 0;
        end else if (en && (en_cnt % DIV) == DIV - 1) begin
          t_cnt[c] <= t_cnt[c] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      chk("tick_o", int'(tick), (en && (en_cnt % DIV) == DIV - 1) ? 1 : 0);
      for (int c = 0; c < N_CH; c++)
        chk($sformatf("led_o[%0d]", c), int'(led[c]), model_led(m_mode[c], t_cnt[c]));
    end
  end

  // Step to the drive point: 2 time units after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_led_change(input int ch, output int n);
    logic prev;
    prev = led[ch];
    n = 0;
    while (led[ch] == prev && n < 300) begin
      cyc();
      n++;
    end
    if (led[ch] == prev) chk($sformatf("timeout led_o[%0d] change", ch), 0, 1);
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    while (!tick && n < 40) begin
      cyc();
      n++;
    end
    if (!tick) chk("timeout tick_o", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d, tk, dbl;
    logic prev_t, prev_l;
    int burst_exp [9];
    burst_exp = '{1, 0, 1, 0, 0, 0, 0, 0, 1};

    rst_n = 1'b0;
    en    = 1'b1;
    mode  = 8'b10_10_10_10;
    run_chk = 1'b1;
    repeat (3) cyc();
    chk("reset led_o", int'(led), 0);
    chk("reset tick_o", int'(tick), 0);

    rst_n = 1'b1;
    cyc();
    chk("entry led_o", int'(led), 4'b1111);

    // First toggle lands on the 3rd tick: entry edge plus 29 more edges.
    wait_led_change(0, n);
    chk("first toggle edges", n, 29);

    n = 0; dbl = 0; prev_t = 1'b0;
    repeat (100) begin
      n += int'(tick);
      if (tick && prev_t) dbl++;
      prev_t = tick;
      cyc();
    end
    chk("ticks per 100 cycles", n, 10);
    chk("back-to-back ticks", dbl, 0);

    wait_led_change(0, n);
    wait_led_change(0, n);
    chk("blink half period", n, 30);
    wait_led_change(0, n);
    chk("blink half period 2", n, 30);

    // ch1 -> BURST: per-tick led pattern from entry.
    mode = 8'b10_10_11_10;
    cyc();
    for (int k = 0; k < 9; k++) begin
      wait_tick();
      chk($sformatf("burst tick %0d", k), int'(led[1]), burst_exp[k]);
      cyc();
    end

    // Freeze for 25 cycles between two toggles of ch0.
    wait_led_change(0, n);
    d = 0;
    repeat (5) begin cyc(); d++; end
    en = 1'b0;
    tk = 0;
    repeat (25) begin tk += int'(tick); cyc(); d++; end
    en = 1'b1;
    wait_led_change(0, n);
    chk("ticks while disabled", tk, 0);
    chk("toggle spacing with pause", d + n, 55);

    // ch2 BLINK -> ON on a tick edge, then ON -> OFF.
    wait_tick();
    mode[5:4] = 2'b01;
    cyc();
    chk("ch2 on after tick", int'(led[2]), 1);
    mode[5:4] = 2'b00;
    cyc();
    chk("ch2 off", int'(led[2]), 0);

    // Asynchronous reset while ch1 sits in B_OFF.
    prev_l = led[1];
    n = 0;
    while (!(prev_l && !led[1]) && n < 200) begin
      prev_l = led[1];
      cyc();
      n++;
    end
    chk("found B_OFF", int'(prev_l && !led[1]), 1);
    rst_n = 1'b0;
    #1;
    chk("async reset led_o", int'(led), 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post-reset led_o", int'(led), 4'b1011);

    // Randomised mode changes, enable toggles and occasional resets.
    repeat (1500) begin
      int r, ch;
      r = int'($urandom_range(0, 199));
      if (r < 16) begin
        ch = int'($urandom_range(0, N_CH - 1));
        mode[2*ch +: 2] = 2'($urandom_range(0, 3));
      end else if (r < 24) begin
        en = ~en;
      end else if (r == 199) begin
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
      cyc();
    end

    run_chk = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_blink_bank.md
Name: led_blink_bank

Overview:
- Parametrised bank of N_CH independent LED drivers sharing one tick prescaler.
- Each channel is set by a 2-bit mode: OFF, ON, BLINK (symmetric square wave) or BURST (BURST_LEN short pulses then a pause).
- Sits between the board switch/control logic and the fpga_LEDRx pins of the top level.
- Generalises the fixed 1 Hz single-LED blinkers: rates, channel count and burst pattern are parameters, and simulation uses small CLK_FREQ/TICK_FREQ values.

Parameters:
- CLK_FREQ, 50_000_000: input clock frequency in Hz.
- TICK_FREQ, 1000: prescaler tick rate in Hz; DIV = CLK_FREQ/TICK_FREQ.
- N_CH, 4: number of LED channels.
- HALF_PERIOD, 500: BLINK half-period, in ticks.
- PULSE_LEN, 100: BURST on-time and off-time, in ticks.
- PAUSE_LEN, 1000: BURST pause after the last pulse, in ticks.
- BURST_LEN, 3: pulses per burst.

Ports:
- fpga_CLK, in, 1: single clock, CLK_FREQ Hz.
- fpga_NRST, in, 1: reset, asynchronous assert, active-low.
- enable_i, in, 1: 1 = run; 0 = freeze prescaler and all channels.
- mode_i, in, 2*N_CH: per-channel mode; channel c uses bits [2c+1:2c]. Synchronous to fpga_CLK.
- tick_o, out, 1: one-cycle prescaler tick (debug/shared).
- led_o, out, N_CH: registered LED drives, 1 = lit.

Behaviour:
- Reset (fpga_NRST=0, asynchronous): all registers cleared; led_o=0; tick_o=0; every mode_q=OFF; all counters 0; burst state B_ON.
- Prescaler:
  - div_cnt counts 0..DIV-1, width $clog2(DIV).
  - tick_o=1 for exactly the cycle where div_cnt==DIV-1 and enable_i=1; div_cnt wraps to 0 on that cycle.
  - enable_i=0: div_cnt holds, tick_o=0.
  - Elaboration error if DIV<2 or any length parameter <1.
- Mode change (per channel):
  - On any edge where mode_i[c] != mode_q[c]: mode_q<=mode_i; phase counter<=0; pulse counter<=0; burst state<=B_ON.
  - led_o[c] takes the entry value on that same edge: OFF 0, ON 1, BLINK 1, BURST 1.
  - Latency from mode_i change to led_o is one clock.
  - A mode change is applied even when enable_i=0.
  - A mode change overrides a coincident tick; that tick is lost for that channel only.
- OFF / ON: led_o constant; counters held at 0.
- BLINK: on each tick, phase_cnt increments. When phase_cnt==HALF_PERIOD-1 on a tick, led_o toggles and phase_cnt<=0. Output period is 2*HALF_PERIOD ticks.
- BURST FSM (per channel, advances only on ticks; phase_cnt counts ticks within a state):
  - B_ON: led=1. After PULSE_LEN ticks -> B_OFF, led<=0, pulse_cnt++.
  - B_OFF: led=0. After PULSE_LEN ticks:
    - if pulse_cnt==BURST_LEN -> B_PAUSE, pulse_cnt<=0;
    - else -> B_ON, led<=1.
  - B_PAUSE: led=0. After PAUSE_LEN ticks -> B_ON, led<=1.
  - Burst period is 2*PULSE_LEN*BURST_LEN + PAUSE_LEN ticks.
  - The transition and the led update happen on the same edge as the terminal tick.
- Widths: phase_cnt is $clog2(max(HALF_PERIOD, PULSE_LEN, PAUSE_LEN)) bits; pulse_cnt is $clog2(BURST_LEN+1) bits. No counter ever exceeds its terminal value (wrap to 0 only).
- Channels are fully independent apart from the shared tick.
- Reset asserted mid-pattern returns to the reset state immediately. After release, channels re-enter their mode through the mode-change rule on the first edge, because mode_q=OFF differs from mode_i.

Decomposition:
- Package led_bank_pkg holds:
  - mode_t enum {MODE_OFF=2'd0, MODE_ON=2'd1, MODE_BLINK=2'd2, MODE_BURST=2'd3};
  - burst_state_t enum {B_ON, B_OFF, B_PAUSE};
  - function clog2_max for counter width.
- Sub-module tick_prescaler (fpga_CLK, fpga_NRST, enable_i, tick_o; parameter DIV).
- The per-channel logic is a generate loop in led_blink_bank.

Test Plan (CLK_FREQ=10, TICK_FREQ=1 so DIV=10; HALF_PERIOD=3, PULSE_LEN=1, PAUSE_LEN=4, BURST_LEN=2, N_CH=4):
- Reset: hold fpga_NRST=0 with mode_i=all BLINK -> led_o=0, tick_o=0. Release -> led_o=4'b1111 one cycle later; tick_o pulses every 10 cycles, high for 1 cycle.
- BLINK ch0: led_o[0] toggles every 30 cycles (3 ticks), 60-cycle period; first toggle on the 3rd tick after entry.
- BURST ch1, per tick: led pattern 1,0,1,0,0,0,0,0, repeating with an 8-tick period.
- enable_i=0 for 25 cycles mid-BLINK -> no tick_o, led_o frozen, div_cnt held; on resume the next toggle is delayed by exactly 25 cycles.
- Mode change coincident with tick, ch2 BLINK->ON -> led_o[2]=1 next cycle, no toggle. Then ON->OFF -> led_o[2]=0 one cycle later; other channels unaffected.
- fpga_NRST asserted mid-B_OFF with no clock edge -> led_o=0 immediately. After release, BURST restarts in B_ON with led=1.
